// File: rtl/flip_pkg.sv
// Shared constants and controller state type for the BRAM flip experiment.
package flip_pkg;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } flip_state_t;

endpackage

// File: rtl/flip_controller.sv
// Flip sequencer: walks the word pairs (p, DEPTH-1-p) and swaps each one through the RAM ports.
//
// state | meaning
// IDLE  | waiting for start
// READ  | both ports read pair p
// WRITE | both ports write back the crossed read data, advance p
// DONE  | one-cycle done pulse, then back to IDLE
module flip_controller
    import flip_pkg::*;
#(
    parameter  int DEPTH = flip_pkg::DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic          we,
    output logic          led_ld,
    output logic          done
);

    localparam logic [AW-1:0] LAST_P = AW'(DEPTH / 2 - 1);
    localparam logic [AW-1:0] TOP    = AW'(DEPTH - 1);

    flip_state_t   state, state_d;
    logic [AW-1:0] p, p_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            p     <= '0;
        end else begin
            state <= state_d;
            p     <= p_d;
        end
    end

    always_comb begin
        state_d = state;
        p_d     = p;
        we      = 1'b0;
        led_ld  = 1'b0;
        done    = 1'b0;
        addr_a  = p;
        addr_b  = TOP - p;
        case (state)
            IDLE: begin
                if (start) begin
                    p_d     = '0;
                    state_d = READ;
                end
            end
            READ: state_d = WRITE;
            WRITE: begin
                we     = 1'b1;
                led_ld = (p == '0);
                if (p == LAST_P) begin
                    state_d = DONE;
                end else begin
                    p_d     = p + 1'b1;
                    state_d = READ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/flip_parser_wrapper.sv
// Wrapper holding the dual-port RAM, the flip controller and the LED mirror of word 0.
module flip_parser_wrapper
    import flip_pkg::*;
#(
    parameter  int DEPTH = flip_pkg::DEPTH,
    parameter  int WIDTH = flip_pkg::WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] leds
);

    typedef logic [WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = WIDTH'(i);
        return m;
    endfunction

    // Power-up image mem[i] = i; reset deliberately leaves the array alone.
    mem_t mem = init_mem();

    logic [AW-1:0]    addr_a, addr_b;
    logic             we, led_ld;
    logic [WIDTH-1:0] rdata_a, rdata_b;

    flip_controller #(.DEPTH(DEPTH)) controller_inst (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .we     (we),
        .led_ld (led_ld),
        .done   ()
    );

    // Both ports share one process; the pair addresses never collide.
    always_ff @(posedge clk) begin
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
        if (we) begin
            mem[addr_a] <= rdata_b;
            mem[addr_b] <= rdata_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds <= 4'b0000;
        end else if (led_ld) begin
            leds <= rdata_b[3:0];
        end
    end

endmodule

// File: tb/tb_flip_parser_wrapper.sv
// Directed-plus-random bench for flip_parser_wrapper against an array model of the RAM.
module tb_flip_parser_wrapper;
    import flip_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] leds;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] model [DEPTH];
    logic [3:0] exp_leds;

    always #5 clk = ~clk;

    flip_parser_wrapper dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .leds  (leds)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reverse_pairs(input int n);
        logic [7:0] t;
        for (int i = 0; i < n; i++) begin
            t                 = model[i];
            model[i]          = model[DEPTH-1-i];
            model[DEPTH-1-i]  = t;
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(dut.mem[i]), 32'(model[i]));
    endtask

    // Called at a negedge; start is sampled at the following posedge (E0).
    // hold: cycles start stays high; repulse: extra start pulse after edge E(repulse).
    task automatic run_flip(input int hold, input int repulse);
        int         done_cnt = 0;
        int         done_k   = -1;
        logic [3:0] old_leds = exp_leds;
        logic [3:0] new_leds = model[DEPTH-1][3:0];
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (dut.controller_inst.done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == 1) chk("leds_before_pair0_write", 32'(leds), 32'(old_leds));
            if (k == 2) chk("leds_after_pair0_write", 32'(leds), 32'(new_leds));
            start = (k < hold - 1) || (k == repulse);
        end
        start = 1'b0;
        chk("done_pulse_count", done_cnt, 1);
        chk("done_edge_after_e0", done_k, 16);
        reverse_pairs(DEPTH / 2);
        exp_leds = new_leds;
        chk("leds_final", 32'(leds), 32'(exp_leds));
        check_mem("mem_after_flip");
    endtask

    initial begin
        int done_seen;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'(i);
        exp_leds = 4'b0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_leds", 32'(leds), 0);
        chk("reset_done", 32'(dut.controller_inst.done), 0);
        chk("reset_state", 32'(dut.controller_inst.state), 32'(IDLE));
        check_mem("mem_init");

        run_flip(1, -1);
        chk("flip1_leds_all_ones", 32'(leds), 32'hF);

        repeat (2) @(negedge clk);
        run_flip(1, -1);
        chk("flip2_leds_zero", 32'(leds), 0);

        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_flip(int'($urandom_range(2, 16)), -1);

        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_flip(1, int'($urandom_range(1, 15)));

        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_flip(int'($urandom_range(2, 16)), int'($urandom_range(1, 15)));

        run_flip(1, -1);
        run_flip(1, -1);

        // Abort after edge E4: pairs 0 and 1 have been written, pair 2 has not.
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_leds", 32'(leds), 0);
        chk("abort_state", 32'(dut.controller_inst.state), 32'(IDLE));
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (dut.controller_inst.done !== 1'b0) done_seen++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (dut.controller_inst.done !== 1'b0) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        reverse_pairs(2);
        exp_leds = 4'b0000;
        check_mem("mem_after_abort");

        run_flip(1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
